sram_bank8: RTL

Eight-bank synchronous coefficient memory for the FIR filter datapath. It is the responder side of the tap-memory interface.
- Writes: an initiator loads 20-bit words one at a time through a single 11-bit combined address (bank select plus row).
- Reads: all eight banks are read in parallel, each at its own 8-bit row address, returning eight 20-bit words one cycle later.
- After reset, a built-in sweep zeroes every row before the block accepts traffic. The filter core never sees uninitialised taps.

---
 rtl/sram_bank8.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sram_bank8.sv
// sram_bank8 -- eight-bank synchronous coefficient memory (tap-memory responder).
//
// Purpose:
//   Holds FIR coefficients as 8 banks x 2**ROW_W rows x DATA_W bits.
//   Single-word writes go through one combined address (bank + row).
//   Reads fetch all eight banks in parallel, each at its own row, with one
//   cycle of latency. After reset a built-in sweep zeroes every row before
//   any access is honoured.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset, dominates CEN/WEN
//   CEN        chip enable, active-low
//   WEN        write enable, active-low (1 = read); ignored when CEN=1
//   CADDR      write address, [ROW_W+2:ROW_W] = bank, [ROW_W-1:0] = row
//   D          write data
//   A0..A7     per-bank read row address
//   Q0..Q7     per-bank registered read data
//   init_done  high once the clear sweep has finished
//
// States:
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_INIT | clear sweep: zero row cnt_q of all banks, ignore accesses
//   ST_RUN  | normal operation: honour reads and writes
module sram_bank8 #(
    parameter int DATA_W = 20,
    parameter int ROW_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 CEN,
    input  logic                 WEN,
    input  logic [ROW_W+2:0]     CADDR,
    input  logic [DATA_W-1:0]    D,
    input  logic [ROW_W-1:0]     A0,
    input  logic [ROW_W-1:0]     A1,
    input  logic [ROW_W-1:0]     A2,
    input  logic [ROW_W-1:0]     A3,
    input  logic [ROW_W-1:0]     A4,
    input  logic [ROW_W-1:0]     A5,
    input  logic [ROW_W-1:0]     A6,
    input  logic [ROW_W-1:0]     A7,
    output logic [DATA_W-1:0]    Q0,
    output logic [DATA_W-1:0]    Q1,
    output logic [DATA_W-1:0]    Q2,
    output logic [DATA_W-1:0]    Q3,
    output logic [DATA_W-1:0]    Q4,
    output logic [DATA_W-1:0]    Q5,
    output logic [DATA_W-1:0]    Q6,
    output logic [DATA_W-1:0]    Q7,
    output logic                 init_done
);

    localparam int NBANK  = 8;
    localparam int BANK_W = 3;
    localparam int ROWS   = 1 << ROW_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ROW_W-1:0]    cnt_q, cnt_d;

    logic [DATA_W-1:0]   mem_q [NBANK][ROWS];
    logic [DATA_W-1:0]   rd_q  [NBANK];
    logic [ROW_W-1:0]    rd_addr [NBANK];

    logic                clr_en;
    logic                wr_en;
    logic                rd_en;
    logic [BANK_W-1:0]   wr_bank;
    logic [ROW_W-1:0]    wr_row;
    logic [DATA_W-1:0]   wr_data;

    assign rd_addr[0] = A0;
    assign rd_addr[1] = A1;
    assign rd_addr[2] = A2;
    assign rd_addr[3] = A3;
    assign rd_addr[4] = A4;
    assign rd_addr[5] = A5;
    assign rd_addr[6] = A6;
    assign rd_addr[7] = A7;

    assign wr_bank = CADDR[ROW_W+2:ROW_W];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_en  = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_row  = cnt_q;
        wr_data = '0;
        case (state_q)
            ST_INIT: begin
                clr_en = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Explicit compare against 0 keeps an undriven WEN from
                // being treated as a write.
                if (CEN == 1'b0) begin
                    if (WEN == 1'b0) begin
                        wr_en   = 1'b1;
                        wr_row  = CADDR[ROW_W-1:0];
                        wr_data = D;
                    end else begin
                        rd_en = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage carries no reset; the sweep clears it instead. During the
    // sweep every bank is written at the same row, otherwise only the
    // addressed bank.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NBANK; k++) begin
            if (!rst && (clr_en || (wr_en && (wr_bank == BANK_W'(k))))) begin
                mem_q[k][wr_row] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NBANK; k++) begin
                rd_q[k] <= '0;
            end
        end else if (rd_en) begin
            for (int k = 0; k < NBANK; k++) begin
                rd_q[k] <= mem_q[k][rd_addr[k]];
            end
        end
    end

    assign Q0 = rd_q[0];
    assign Q1 = rd_q[1];
    assign Q2 = rd_q[2];
    assign Q3 = rd_q[3];
    assign Q4 = rd_q[4];
    assign Q5 = rd_q[5];
    assign Q6 = rd_q[6];
    assign Q7 = rd_q[7];

    assign init_done = (state_q == ST_RUN);

endmodule
